// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble serializer and its accumulating receiver.
package nibble_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {IDLE, SEND, DONE} ser_state_t;
endpackage

// File: rtl/nibble_serializer_rise_detect.sv
// 0->1 edge detector for a level input synchronous to clk.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);
  logic in_q;

  // History resets high so an input held high through reset never reads as a rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_q <= 1'b1;
    else     in_q <= in;
  end

  assign pulse = in & ~in_q;
endmodule

// File: rtl/nibble_serializer.sv
// Word-to-nibble unloader: loads a word, then presents it MSB nibble first,
// advancing on each rising edge of step.
module nibble_serializer
  import nibble_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load_valid,
  output logic                               load_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]        word_in,
  input  logic                               step,
  output logic [NIBBLE_W-1:0]                nib_out,
  output logic                               nib_valid,
  output logic [$clog2(NIBBLES)-1:0]         nib_idx,
  output logic                               busy,
  output logic                               done,
  output logic [1:0]                         dbg_state
);
  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);

  ser_state_t       state;
  logic [W-1:0]     sr;
  logic [IDX_W-1:0] idx;
  logic             rise;

  rise_detect u_rise (
    .clk   (clk),
    .rst   (rst),
    .in    (step),
    .pulse (rise)
  );

  // Load handshake: a word transfers on any rising clk edge where load_valid and
  // load_ready are both high; the source holds word_in until then, nothing is queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sr    <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            sr    <= word_in;
            idx   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (rise) begin
            sr <= {sr[W-NIBBLE_W-1:0], {NIBBLE_W{1'b0}}};
            if (idx == IDX_W'(NIBBLES - 1)) begin
              idx   <= '0;
              state <= DONE;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode from state and registers only; nothing combinational from inputs.
  assign load_ready = (state == IDLE);
  assign nib_valid  = (state == SEND);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign nib_out    = nib_valid ? sr[W-1 -: NIBBLE_W] : '0;
  assign nib_idx    = idx;
  assign dbg_state  = state;
endmodule

// File: tb/tb_nibble_serializer.sv
// Directed bench for nibble_serializer with a loopback nibble accumulator model.
module tb_nibble_serializer;
  import nibble_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] word_in = '0;
  logic        step = 1'b0;
  logic [3:0]  nib_out;
  logic        nib_valid;
  logic [1:0]  nib_idx;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  // Receiver model: shifts nib_out in on each rise of the shared step.
  logic        acc_q;
  logic [15:0] acc;

  nibble_serializer #(.NIBBLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .word_in    (word_in),
    .step       (step),
    .nib_out    (nib_out),
    .nib_valid  (nib_valid),
    .nib_idx    (nib_idx),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= 1'b1;
      acc   <= '0;
    end else begin
      acc_q <= step;
      if (step & ~acc_q) acc <= {acc[11:0], nib_out};
    end
  end

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_nib(input string tag, input logic [3:0] n, input logic [1:0] i);
    chk({tag, "_valid"}, nib_valid, 1'b1);
    chk({tag, "_nib"}, nib_out, n);
    chk({tag, "_idx"}, nib_idx, i);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, load_ready, 1'b1);
    chk({tag, "_valid"}, nib_valid, 1'b0);
    chk({tag, "_nib"}, nib_out, 4'h0);
    chk({tag, "_idx"}, nib_idx, 2'd0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  task automatic load(input logic [15:0] w);
    int n;
    n = 0;
    while (!load_ready && n < 20) begin
      cyc();
      n++;
    end
    chk("load_wait", (n < 20), 1'b1);
    load_valid = 1'b1;
    word_in    = w;
    cyc();
    load_valid = 1'b0;
  endtask

  task automatic pulse();
    step = 1'b1;
    cyc();
    step = 1'b0;
    cyc();
  endtask

  task automatic send_word(input string tag, input logic [15:0] w);
    int d0;
    d0 = done_cnt;
    load(w);
    chk_nib({tag, "_n0"}, w[15:12], 2'd0);
    repeat (4) pulse();
    chk({tag, "_acc"}, acc, w);
    chk({tag, "_donecnt"}, done_cnt - d0, 1);
    chk({tag, "_ready"}, load_ready, 1'b1);
  endtask

  initial begin
    // Reset state
    repeat (2) cyc();
    chk_idle("rst");
    chk("rst_state", dbg_state, IDLE);
    rst = 1'b0;
    cyc();
    chk_idle("post_rst");

    // A5C3 with clean pulses
    load(16'hA5C3);
    chk_nib("a5_n0", 4'hA, 2'd0);
    chk("a5_busy", busy, 1'b1);
    chk("a5_ready", load_ready, 1'b0);
    chk("a5_state", dbg_state, SEND);
    cyc();
    chk_nib("a5_hold", 4'hA, 2'd0);
    pulse();
    chk_nib("a5_n1", 4'h5, 2'd1);
    pulse();
    chk_nib("a5_n2", 4'hC, 2'd2);
    pulse();
    chk_nib("a5_n3", 4'h3, 2'd3);
    step = 1'b1;
    cyc();
    chk("a5_done", done, 1'b1);
    chk("a5_done_valid", nib_valid, 1'b0);
    chk("a5_done_nib", nib_out, 4'h0);
    chk("a5_done_busy", busy, 1'b1);
    chk("a5_done_ready", load_ready, 1'b0);
    step = 1'b0;
    cyc();
    chk_idle("a5_end");
    chk("a5_acc", acc, 16'hA5C3);
    chk("a5_donecnt", done_cnt, 1);

    // Held step gives one advance; load_valid in SEND is ignored
    load(16'h7E29);
    step = 1'b1;
    repeat (10) cyc();
    chk_nib("hold_n1", 4'hE, 2'd1);
    step = 1'b0;
    load_valid = 1'b1;
    word_in    = 16'h1234;
    cyc();
    chk_nib("ign_n1", 4'hE, 2'd1);
    pulse();
    chk_nib("ign_n2", 4'h2, 2'd2);
    pulse();
    chk_nib("ign_n3", 4'h9, 2'd3);
    load_valid = 1'b0;
    pulse();
    chk_idle("ign_end");
    chk("ign_acc", acc, 16'h7E29);
    chk("ign_donecnt", done_cnt, 2);

    // Load and rise together in IDLE: rise discarded
    load_valid = 1'b1;
    word_in    = 16'h1B6D;
    step       = 1'b1;
    cyc();
    load_valid = 1'b0;
    chk_nib("sim_n0", 4'h1, 2'd0);
    repeat (3) cyc();
    chk_nib("sim_hold", 4'h1, 2'd0);
    step = 1'b0;
    cyc();
    chk_nib("sim_low", 4'h1, 2'd0);
    pulse();
    chk_nib("sim_n1", 4'hB, 2'd1);
    repeat (3) pulse();
    chk_idle("sim_end");
    chk("sim_acc", acc, 16'h1B6D);
    chk("sim_donecnt", done_cnt, 3);

    // Reset mid-word after two steps
    load(16'hCAFE);
    pulse();
    pulse();
    chk_nib("mid_n2", 4'hF, 2'd2);
    rst = 1'b1;
    #1;
    chk_idle("mid_rst_async");
    cyc();
    rst = 1'b0;
    cyc();
    chk_idle("mid_after");
    chk("mid_donecnt", done_cnt, 3);

    // Step held high through reset release
    step = 1'b1;
    rst  = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    chk_idle("shr_idle");
    load(16'h3C5A);
    cyc();
    cyc();
    chk_nib("shr_n0", 4'h3, 2'd0);
    step = 1'b0;
    cyc();
    chk_nib("shr_low", 4'h3, 2'd0);
    pulse();
    chk_nib("shr_n1", 4'hC, 2'd1);
    repeat (3) pulse();
    chk_idle("shr_end");
    chk("shr_acc", acc, 16'h3C5A);
    chk("shr_donecnt", done_cnt, 4);

    // Loopback words
    send_word("lb_ffff", 16'hFFFF);
    send_word("lb_0000", 16'h0000);
    send_word("lb_8001", 16'h8001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nibble_serializer.md
# nibble_serializer

Parallel-to-nibble unloader, the transmit-side counterpart of the team's 16-bit nibble-accumulating shift register. It accepts a 16-bit word through a ready/valid load port and presents it one 4-bit nibble at a time, most-significant nibble first, advancing on each rising edge of a step input (a debounced push-button or a tick). A downstream nibble accumulator fed by `nib_out` and pulsed by the same steps rebuilds the original word. It sits between a word source (register bank or ALU result) and 4-bit-wide consumers such as the display or LED path.

## Interface
- `NIBBLES`, default 4: nibbles per word; word width is `4*NIBBLES`.
- `clk` input 1: single system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `load_valid` input 1: source offers `word_in` this cycle.
- `load_ready` output 1: block can accept a word (high only in IDLE).
- `word_in` input `4*NIBBLES`: word to serialize.
- `step` input 1: level advance request, synchronous to `clk`; only the 0->1 transition counts.
- `nib_out` output 4: current nibble.
- `nib_valid` output 1: `nib_out` holds a nibble of the current word.
- `nib_idx` output `$clog2(NIBBLES)`: index of the presented nibble, 0 = most significant.
- `busy` output 1: high in SEND and DONE.
- `done` output 1: one-cycle pulse after the last nibble has been stepped past.

## Operation
- Reset (async, immediate): state IDLE; shift register 0; `nib_idx` 0; step history register 1 (a step held high through reset never produces a rise); outputs `load_ready`=1, `nib_valid`=0, `nib_out`=0, `busy`=0, `done`=0.
- Rise detect: `rise = step & ~step_q`; `step_q <= step` every cycle, in every state.
- FSM states IDLE, SEND, DONE.
  - IDLE: `load_ready`=1. On `load_valid`: capture `word_in`, `nib_idx`<=0, go SEND. `rise` is ignored.
  - SEND: `nib_valid`=1, `nib_out` = upper 4 bits of the shift register. On `rise`: shift left by 4 with zero fill, `nib_idx`++. If `nib_idx`==NIBBLES-1 at the rise, go DONE instead.
  - DONE: exactly one cycle; `done`=1, `nib_valid`=0, then IDLE.
- `load_valid` in SEND or DONE is ignored; the word is not queued, and the source must hold it until `load_ready`.
- `load_valid` and `rise` in the same IDLE cycle: load is taken and the rise is discarded. The first nibble still needs a fresh rise.
- `nib_out` is 0 whenever `nib_valid`=0. After NIBBLES shifts the register is all zero by construction.
- Reset in SEND or DONE aborts the word with no `done` pulse.

## Timing
- All outputs are registered or decoded from state and registers only. There is no combinational path from any input to any output.
- A load handshake at edge N makes `nib_valid`=1 and `nib_out`=`word_in[15:12]` visible from N+1.
- `step` 0->1 sampled at edge M makes the next nibble visible from M+1. Minimum spacing is 2 cycles, because `step` must be seen low between rises.
- The NIBBLES-th rise at edge M gives `done`=1 during cycle M+1 and `load_ready`=1 from M+2.
- Back-to-back words: minimum period is 2 + 2·NIBBLES cycles with a continuously toggling `step`.

## Structure
- Shared package `nibble_pkg`:
  - `NIBBLE_W` = 4.
  - `typedef enum logic [1:0] {IDLE, SEND, DONE} ser_state_t`.
  - This package is shared with the accumulating receiver.
- Sub-module `rise_detect` (`clk`, `rst`, `in`, `pulse`). Its history flop resets to 1. It is reusable for the receiver's button input.
- Top: FSM, shift register, index counter.

## Test plan
- Load 16'hA5C3, then 4 clean step pulses: `nib_out` reads A, 5, C, 3 with `nib_idx` 0..3; `done` pulses once; `load_ready` returns high.
- Hold `step` high for 10 cycles in SEND: exactly one advance.
- `load_valid` with 16'h1234 while in SEND: ignored, and the remaining nibbles of the current word are unchanged.
- `load_valid` and a step rise in the same IDLE cycle: the word loads and `nib_out`=1 persists until the next rise.
- Assert `rst` mid-word after 2 steps, and separately with `step` held high through reset release: all outputs return to reset values, no `done` pulse, no spurious advance.
- Loopback into the nibble accumulator, sharing the steps, with 16'hFFFF, 16'h0000 and 16'h8001: the accumulator's output equals the sent word after 4 steps.
